// File: rtl/prog_mealy_fsm.sv
// Table-driven, runtime-programmable Mealy machine. Each {state, input} entry holds
// a next state, an output and a valid flag, loaded through a config write port.
module prog_mealy_fsm #(
    parameter int SW = 3,
    parameter int IW = 2,
    parameter int OW = 1,
    parameter int CW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SW-1:0]    state_in,
    input  logic [IW-1:0]    sw_in,
    input  logic             ctrl_in,
    input  logic             cfg_we,
    input  logic [SW+IW-1:0] cfg_addr,
    input  logic [SW-1:0]    cfg_next,
    input  logic [OW-1:0]    cfg_out,
    output logic [SW-1:0]    state,
    output logic [OW-1:0]    out,
    output logic [OW-1:0]    out_comb,
    output logic             entry_valid,
    output logic             err,
    output logic [CW-1:0]    step_cnt
);

    localparam int AW = SW + IW;
    localparam int NE = 1 << AW;

    logic [SW-1:0] next_tbl [NE];
    logic [OW-1:0] out_tbl  [NE];
    logic [NE-1:0] valid_tbl;

    logic [AW-1:0] rd_idx;
    logic          rd_valid;
    logic [SW-1:0] rd_next;
    logic [OW-1:0] rd_out;

    // Step counter wraps modulo 2**CW.
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
        return v + CW'(1);
    endfunction

    // Lookup of the entry addressed by the current state and input symbol.
    assign rd_idx      = {state, sw_in};
    assign rd_valid    = valid_tbl[rd_idx];
    assign rd_next     = next_tbl[rd_idx];
    assign rd_out      = out_tbl[rd_idx];
    assign entry_valid = rd_valid;
    assign out_comb    = rd_valid ? rd_out : '0;

    // Only the valid flags are reset; a reset therefore discards the whole table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_tbl <= '0;
        end else if (cfg_we) begin
            valid_tbl[cfg_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            next_tbl[cfg_addr] <= cfg_next;
            out_tbl[cfg_addr]  <= cfg_out;
        end
    end

    // Steps read the table as it stood before the edge, so a same-cycle write is read-old.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= state_in;
            out      <= '0;
            err      <= 1'b0;
            step_cnt <= '0;
        end else if (ctrl_in) begin
            if (rd_valid) begin
                state    <= rd_next;
                out      <= rd_out;
                step_cnt <= cnt_inc(step_cnt);
            end else begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_mealy_fsm.sv
// Directed bench for prog_mealy_fsm (SW=3, IW=2, OW=1, CW=4) with immediate assertions.
module tb_prog_mealy_fsm;

    logic       clk;
    logic       reset;
    logic [2:0] state_in;
    logic [1:0] sw_in;
    logic       ctrl_in;
    logic       cfg_we;
    logic [4:0] cfg_addr;
    logic [2:0] cfg_next;
    logic [0:0] cfg_out;
    logic [2:0] state;
    logic [0:0] out;
    logic [0:0] out_comb;
    logic       entry_valid;
    logic       err;
    logic [3:0] step_cnt;

    int checks = 0;
    int errors = 0;

    prog_mealy_fsm #(.SW(3), .IW(2), .OW(1), .CW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .state_in    (state_in),
        .sw_in       (sw_in),
        .ctrl_in     (ctrl_in),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_next    (cfg_next),
        .cfg_out     (cfg_out),
        .state       (state),
        .out         (out),
        .out_comb    (out_comb),
        .entry_valid (entry_valid),
        .err         (err),
        .step_cnt    (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] s);
        state_in = s;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [2:0] n, input logic o);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_next = n;
        cfg_out  = o;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic step(input logic [1:0] s);
        sw_in   = s;
        ctrl_in = 1'b1;
        tick();
        ctrl_in = 1'b0;
    endtask

    task automatic program_legacy();
        wr(5'd0, 3'd0, 1'b1);
        wr(5'd1, 3'd0, 1'b0);
        wr(5'd2, 3'd1, 1'b1);
        wr(5'd3, 3'd1, 1'b1);
        wr(5'd4, 3'd0, 1'b0);
        wr(5'd5, 3'd1, 1'b1);
        wr(5'd6, 3'd1, 1'b1);
        wr(5'd7, 3'd1, 1'b0);
    endtask

    logic exp_oc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        reset = 1'b1; state_in = 3'd5; sw_in = 2'd0; ctrl_in = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_next = '0; cfg_out = '0;

        // Reset state and stepping on an empty table
        do_reset(3'd5);
        check("rst_state", 32'(state), 32'd5);
        check("rst_out", 32'(out), 32'd0);
        check("rst_cnt", 32'(step_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_valid", 32'(entry_valid), 32'd0);
        step(2'd0);
        check("empty_state", 32'(state), 32'd5);
        check("empty_out", 32'(out), 32'd0);
        check("empty_cnt", 32'(step_cnt), 32'd0);
        check("empty_err", 32'(err), 32'd1);
        check("empty_valid", 32'(entry_valid), 32'd0);
        check("empty_oc", 32'(out_comb), 32'd0);

        // Legacy two-state machine
        do_reset(3'd0);
        check("leg_rst_err", 32'(err), 32'd0);
        program_legacy();
        step(2'd2);
        check("leg1_state", 32'(state), 32'd1);
        check("leg1_out", 32'(out), 32'd1);
        step(2'd3);
        check("leg2_state", 32'(state), 32'd1);
        check("leg2_out", 32'(out), 32'd0);
        step(2'd0);
        check("leg3_state", 32'(state), 32'd0);
        check("leg3_out", 32'(out), 32'd0);
        step(2'd1);
        check("leg4_state", 32'(state), 32'd0);
        check("leg4_out", 32'(out), 32'd0);
        check("leg_cnt", 32'(step_cnt), 32'd4);
        check("leg_err", 32'(err), 32'd0);

        // ctrl_in low: nothing moves, out_comb follows the table
        for (int i = 0; i < 10; i++) begin
            sw_in = 2'(i % 4);
            tick();
            check("hold_state", 32'(state), 32'd0);
            check("hold_out", 32'(out), 32'd0);
            check("hold_oc", 32'(out_comb), 32'(exp_oc[i % 4]));
        end
        check("hold_cnt", 32'(step_cnt), 32'd4);

        // Same-cycle write and step on {0,2}: step reads old entry, write still lands
        sw_in = 2'd2; ctrl_in = 1'b1;
        cfg_we = 1'b1; cfg_addr = 5'd2; cfg_next = 3'd0; cfg_out = 1'b0;
        tick();
        ctrl_in = 1'b0; cfg_we = 1'b0;
        check("rw_state", 32'(state), 32'd1);
        check("rw_out", 32'(out), 32'd1);
        check("rw_cnt", 32'(step_cnt), 32'd5);
        step(2'd0);
        check("rw_back_state", 32'(state), 32'd0);
        sw_in = 2'd2;
        #1;
        check("rw_new_valid", 32'(entry_valid), 32'd1);
        check("rw_new_oc", 32'(out_comb), 32'd0);
        step(2'd2);
        check("rw_new_state", 32'(state), 32'd0);
        check("rw_new_out", 32'(out), 32'd0);

        // After reset the table is gone; writing and stepping the same invalid entry sets err
        do_reset(3'd0);
        sw_in = 2'd2; ctrl_in = 1'b1;
        cfg_we = 1'b1; cfg_addr = 5'd2; cfg_next = 3'd1; cfg_out = 1'b1;
        tick();
        ctrl_in = 1'b0; cfg_we = 1'b0;
        check("lost_state", 32'(state), 32'd0);
        check("lost_out", 32'(out), 32'd0);
        check("lost_err", 32'(err), 32'd1);
        check("lost_cnt", 32'(step_cnt), 32'd0);
        check("lost_wr_valid", 32'(entry_valid), 32'd1);
        check("lost_wr_oc", 32'(out_comb), 32'd1);

        // Counter wrap on self-loop {0,0}->(0,1)
        do_reset(3'd0);
        wr(5'd0, 3'd0, 1'b1);
        for (int i = 0; i < 15; i++) step(2'd0);
        check("wrap_cnt15", 32'(step_cnt), 32'd15);
        step(2'd0);
        check("wrap_cnt0", 32'(step_cnt), 32'd0);
        check("wrap_state", 32'(state), 32'd0);
        check("wrap_out", 32'(out), 32'd1);
        check("wrap_err", 32'(err), 32'd0);

        // Async reset between edges after some progress and a sticky err
        step(2'd0);
        step(2'd0);
        step(2'd1);
        check("pre_cnt", 32'(step_cnt), 32'd2);
        check("pre_err", 32'(err), 32'd1);
        sw_in = 2'd0;
        #2;
        state_in = 3'd2;
        reset    = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'd2);
        check("arst_out", 32'(out), 32'd0);
        check("arst_cnt", 32'(step_cnt), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_valid", 32'(entry_valid), 32'd0);
        check("arst_oc", 32'(out_comb), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("arst_hold_state", 32'(state), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
